// File: rtl/matrix_pkg.sv
// matrix_pkg: shared widths, opcode constants and sequencer state encoding
package matrix_pkg;
    localparam int DEF_MAT_W  = 256;
    localparam int DEF_ADDR_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        EXEC,
        WR,
        DONE,
        ERR
    } seq_state_t;
endpackage

// File: rtl/mat_rd_wait.sv
// mat_rd_wait: loadable down-counter that marks the last cycle of a RAM read state
module mat_rd_wait #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic last_cycle
);
    localparam int CW = $clog2(RD_LAT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Reload to the full read latency on every state entry, else count down to zero
    always_comb begin
        cnt_d = load ? CW'(RD_LAT) : (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign last_cycle = (cnt_q == CW'(1));
endmodule

// File: rtl/matrix_op_sequencer.sv
// matrix_op_sequencer: runs one add/sub instruction (read A, read B, execute, write back)
// over the single-port matrix RAM. Optional SEQ_CYCLE_COUNT_EN adds perf_cycles.
module matrix_op_sequencer
    import matrix_pkg::*;
#(
    parameter int MAT_W  = DEF_MAT_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        opcode,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_c,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    output logic [MAT_W-1:0]  ram_wdata,
    input  logic [MAT_W-1:0]  ram_rdata,
    output logic [MAT_W-1:0]  op_a,
    output logic [MAT_W-1:0]  op_b,
`ifdef SEQ_CYCLE_COUNT_EN
    output logic [15:0]       perf_cycles,
`endif
    output logic              alu_sel,
    input  logic [MAT_W-1:0]  alu_result
);
    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [ADDR_W-1:0] addr_c_q, addr_c_d;
    logic [MAT_W-1:0]  op_a_q, op_a_d;
    logic [MAT_W-1:0]  op_b_q, op_b_d;
    logic [MAT_W-1:0]  wdata_q, wdata_d;
    logic              alu_sel_q, alu_sel_d;
    logic              accept, op_valid, last_cycle, rd_load;

    assign accept   = (state_q == IDLE) && start;
    assign op_valid = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign rd_load  = (state_d != state_q);

    mat_rd_wait #(.RD_LAT(RD_LAT)) u_rd_wait (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (rd_load),
        .last_cycle (last_cycle)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; reserved opcodes divert to a one-cycle error state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = op_valid ? RD_A : ERR;
            RD_A:      if (last_cycle) state_d = RD_B;
            RD_B:      if (last_cycle) state_d = EXEC;
            EXEC:      state_d = WR;
            WR:        state_d = DONE;
            DONE, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs decoded purely from registered state and latched addresses
    always_comb begin
        busy        = state_q inside {RD_A, RD_B, EXEC, WR, DONE};
        done        = (state_q == DONE);
        error       = (state_q == ERR);
        ram_wren    = (state_q == WR);
        ram_address = (state_q == RD_A) ? addr_a_q :
                      (state_q == RD_B) ? addr_b_q :
                      (state_q == WR)   ? addr_c_q : '0;
    end

    // Datapath next values: latch the instruction on accept, operands on the last read cycle
    always_comb begin
        addr_a_d  = accept ? addr_a : addr_a_q;
        addr_b_d  = accept ? addr_b : addr_b_q;
        addr_c_d  = accept ? addr_c : addr_c_q;
        alu_sel_d = (accept && op_valid) ? (opcode == OP_SUB) : alu_sel_q;
        op_a_d    = (state_q == RD_A && last_cycle) ? ram_rdata : op_a_q;
        op_b_d    = (state_q == RD_B && last_cycle) ? ram_rdata : op_b_q;
        wdata_d   = (state_q == EXEC) ? alu_result : wdata_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            addr_c_q  <= '0;
            alu_sel_q <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            wdata_q   <= '0;
        end else begin
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            addr_c_q  <= addr_c_d;
            alu_sel_q <= alu_sel_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            wdata_q   <= wdata_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign ram_wdata = wdata_q;
    assign alu_sel   = alu_sel_q;

`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0] perf_q, perf_d;

    // Cycle count of the active phase (RD_A..WR), cleared on an accepted instruction
    always_comb begin
        perf_d = (accept && op_valid) ? 16'd0 :
                 (state_q inside {RD_A, RD_B, EXEC, WR} && perf_q != 16'hFFFF) ? perf_q + 16'd1 :
                 perf_q;
    end

    // Performance counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_matrix_op_sequencer.sv
// tb_matrix_op_sequencer: randomized self-checking bench with RAM/ALU models and a memory-level reference
module tb_matrix_op_sequencer;
    localparam int MAT_W    = 256;
    localparam int ADDR_W   = 8;
    localparam int RD_LAT   = 2;
    localparam int DONE_CYC = 2 * RD_LAT + 3;
    localparam int WR_CYC   = 2 * RD_LAT + 2;
    localparam int EXEC_CYC = 2 * RD_LAT + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        opcode = 2'b00;
    logic [ADDR_W-1:0] addr_a = '0, addr_b = '0, addr_c = '0;
    logic              busy, done, error, ram_wren, alu_sel;
    logic [ADDR_W-1:0] ram_address;
    logic [MAT_W-1:0]  ram_wdata, ram_rdata, op_a, op_b, alu_result;
`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0]       perf_cycles;
`endif

    logic              tb_we = 1'b0;
    logic [ADDR_W-1:0] tb_waddr = '0;
    logic [MAT_W-1:0]  tb_wdata = '0;
    logic [MAT_W-1:0]  mem     [256];
    logic [MAT_W-1:0]  ref_mem [256];

    int checks = 0;
    int failures = 0;
    int done_n, done_cyc, err_n, err_cyc, wr_n, wr_cyc, busy_n;
    logic [ADDR_W-1:0] wr_addr;
    logic              sel_exec;

    always #5 clk = ~clk;

    matrix_op_sequencer #(.MAT_W(MAT_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .opcode      (opcode),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .addr_c      (addr_c),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .ram_address (ram_address),
        .ram_wren    (ram_wren),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .op_a        (op_a),
        .op_b        (op_b),
`ifdef SEQ_CYCLE_COUNT_EN
        .perf_cycles (perf_cycles),
`endif
        .alu_sel     (alu_sel),
        .alu_result  (alu_result)
    );

    function automatic logic [MAT_W-1:0] badd(input logic [MAT_W-1:0] x, input logic [MAT_W-1:0] y);
        logic [MAT_W-1:0] r;
        for (int i = 0; i < MAT_W / 8; i++) r[i*8 +: 8] = x[i*8 +: 8] + y[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [MAT_W-1:0] bsub(input logic [MAT_W-1:0] x, input logic [MAT_W-1:0] y);
        logic [MAT_W-1:0] r;
        for (int i = 0; i < MAT_W / 8; i++) r[i*8 +: 8] = x[i*8 +: 8] - y[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [MAT_W-1:0] rand_mat();
        logic [MAT_W-1:0] r;
        for (int i = 0; i < MAT_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // External byte-lane adder/subtractor units feeding the sequencer
    assign alu_result = alu_sel ? bsub(op_a, op_b) : badd(op_a, op_b);

    // Single-port RAM with one registered read stage; bench preload port has priority
    always @(posedge clk) begin
        if (tb_we) mem[tb_waddr] <= tb_wdata;
        else if (ram_wren) mem[ram_address] <= ram_wdata;
        ram_rdata <= mem[ram_address];
    end

    task automatic check(input string tag, input logic [MAT_W-1:0] got, input logic [MAT_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ram_put(input logic [ADDR_W-1:0] a, input logic [MAT_W-1:0] d);
        tb_we = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
        ref_mem[a] = d;
    endtask

    // Issue one instruction at the current negedge and observe ncyc cycles;
    // xs>0 injects a second start (to address xc) in cycle xs.
    task automatic run_op(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                          input logic [ADDR_W-1:0] c, input int ncyc, input int xs, input logic [ADDR_W-1:0] xc);
        start = 1'b1;
        opcode = op;
        addr_a = a;
        addr_b = b;
        addr_c = c;
        done_n = 0; done_cyc = 0; err_n = 0; err_cyc = 0; wr_n = 0; wr_cyc = 0; busy_n = 0;
        wr_addr = '0;
        sel_exec = 1'b0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                opcode = 2'($urandom);
                addr_a = 8'($urandom);
                addr_b = 8'($urandom);
                addr_c = 8'($urandom);
            end
            if (n == xs) begin
                start = 1'b1;
                opcode = 2'b00;
                addr_c = xc;
            end
            if (n == xs + 1) start = 1'b0;
            if (done) begin done_n++; done_cyc = n; end
            if (error) begin err_n++; err_cyc = n; end
            if (ram_wren) begin wr_n++; wr_cyc = n; wr_addr = ram_address; end
            if (busy) busy_n++;
            if (n == EXEC_CYC) sel_exec = alu_sel;
        end
    endtask

    // Run an instruction, advance the reference memory, and check timing and result
    task automatic do_op(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                         input logic [ADDR_W-1:0] c, input int xs, input logic [ADDR_W-1:0] xc);
        int ncyc;
        ncyc = op[1] ? 2 : DONE_CYC + 1;
        run_op(op, a, b, c, ncyc, xs, xc);
        if (!op[1]) begin
            ref_mem[c] = op[0] ? bsub(ref_mem[a], ref_mem[b]) : badd(ref_mem[a], ref_mem[b]);
            check("done_count", 256'(done_n), 256'(1));
            check("done_cycle", 256'(done_cyc), 256'(DONE_CYC));
            check("wren_count", 256'(wr_n), 256'(1));
            check("wren_cycle", 256'(wr_cyc), 256'(WR_CYC));
            check("wren_addr", 256'(wr_addr), 256'(c));
            check("busy_cycles", 256'(busy_n), 256'(DONE_CYC));
            check("alu_sel_exec", 256'(sel_exec), 256'(op[0]));
            check("no_error", 256'(err_n), 256'(0));
`ifdef SEQ_CYCLE_COUNT_EN
            check("perf_cycles", 256'(perf_cycles), 256'(2 * RD_LAT + 2));
`endif
        end else begin
            check("err_count", 256'(err_n), 256'(1));
            check("err_cycle", 256'(err_cyc), 256'(1));
            check("err_no_wren", 256'(wr_n), 256'(0));
            check("err_no_busy", 256'(busy_n), 256'(0));
            check("err_no_done", 256'(done_n), 256'(0));
        end
        check("ram_result", mem[c], ref_mem[c]);
    endtask

    // Start an add into c, then assert reset asynchronously in cycle cyc
    task automatic mid_reset(input int cyc, input logic [ADDR_W-1:0] c);
        start = 1'b1;
        opcode = 2'b00;
        addr_a = 8'd0;
        addr_b = 8'd1;
        addr_c = c;
        for (int n = 1; n <= cyc; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        if (cyc == WR_CYC) check("wren_before_rst", 256'(ram_wren), 256'(1));
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 256'(busy), 256'(0));
        check("rst_mid_wren", 256'(ram_wren), 256'(0));
        check("rst_mid_addr", 256'(ram_address), 256'(0));
        check("rst_mid_op_a", op_a, '0);
        check("rst_mid_wdata", ram_wdata, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_nowrite", mem[c], ref_mem[c]);
    endtask

    initial begin
        logic [MAT_W-1:0] mat_a, ones;
        logic [1:0] op;
        for (int i = 0; i < MAT_W / 8; i++) begin
            mat_a[i*8 +: 8] = 8'(i + 1);
            ones[i*8 +: 8] = 8'h01;
        end

        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_error", 256'(error), 256'(0));
        check("rst_wren", 256'(ram_wren), 256'(0));
        check("rst_addr", 256'(ram_address), 256'(0));
        check("rst_wdata", ram_wdata, '0);
        check("rst_op_a", op_a, '0);
        check("rst_op_b", op_b, '0);
        check("rst_alu_sel", 256'(alu_sel), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        ram_put(8'd0, mat_a);
        ram_put(8'd1, ones);
        ram_put(8'd2, rand_mat());
        ram_put(8'd3, rand_mat());
        ram_put(8'd4, rand_mat());
        ram_put(8'd5, rand_mat());

        do_op(2'b00, 8'd0, 8'd1, 8'd2, 0, 8'd0);
        check("t1_add_value", mem[2], badd(mat_a, ones));
        do_op(2'b01, 8'd0, 8'd1, 8'd2, 0, 8'd0);
        check("t2_sub_value", mem[2], bsub(mat_a, ones));
        do_op(2'b10, 8'd0, 8'd1, 8'd3, 0, 8'd0);
        do_op(2'b11, 8'd0, 8'd1, 8'd3, 0, 8'd0);
        do_op(2'b00, 8'd0, 8'd1, 8'd4, 3, 8'd5);
        check("t4_ignored_dest", mem[5], ref_mem[5]);

        mid_reset(3, 8'd2);
        do_op(2'b00, 8'd0, 8'd1, 8'd2, 0, 8'd0);
        mid_reset(WR_CYC, 8'd3);
        do_op(2'b01, 8'd1, 8'd0, 8'd3, 0, 8'd0);

        do_op(2'b00, 8'd0, 8'd1, 8'd0, 0, 8'd0);
        check("t6_alias_value", mem[0], badd(mat_a, ones));
        do_op(2'b00, 8'd0, 8'd1, 8'd6, 0, 8'd0);
        check("t6_chain_value", mem[6], badd(badd(mat_a, ones), ones));

        for (int i = 0; i < 16; i++) ram_put(8'(i), rand_mat());
        for (int k = 0; k < 24; k++) begin
            op = ($urandom_range(0, 7) == 0) ? {1'b1, 1'($urandom)} : {1'b0, 1'($urandom)};
            do_op(op, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                  8'($urandom_range(0, 15)), 0, 8'd0);
        end
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
